bus_control_sequencer: RTL
==========================

// Module: bus_control_sequencer
// PURPOSE
//  Hardwired control unit for the single-bus 32-bit datapath. A one-hot-strobe FSM runs fetch (T0-T2) and execute (T3-T7).
//  It drives every register Rin/Rout, PC/IR/MAR/MDR/Y/Z/HI/LO strobe, the 4-bit ALU control and IncPc.
//  It handshakes with memory through read/write/mem_ready and stalls on mul/div.
// PARAMETERS
//  MULDIV_CYCLES  4   cycles T4 is held (Zin asserted) for mul/div before Z is taken
//  NREGS          16  general registers addressed by 4-bit fields
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  reset      in   1   asynchronous, active-low (0 = reset)
//  ir         in   32  IR contents: op[31:27] Ra[26:23] Rb[22:19] Rc[18:15] C[18:0]
//  mem_ready  in   1   memory completed current read/write this cycle
//  stop       in   1   request halt at next instruction boundary
//  Rin        out  16  one-hot register load enables R0in..R15in
//  Rout       out  16  one-hot register bus drivers R0out..R15out
//  PCout,PCin,IncPc,IRin,MARin,MDRin,MDRout,Yin,Zin,Zlowout,Zhighout,HIin,HIout,LOin,LOout,Cout  out 1 each
//  control    out  4   ALU operation code
//  read,write out  1   memory strobes; held until mem_ready
//  run        out  1   1 while executing; 0 in HALT
//  illegal    out  1   sticky illegal-opcode flag (ILLEGAL_TRAP_EN only, else tied 0)
//  tstate     out  3   current T-step, for debug
// BEHAVIOUR
//  - Reset (reset=0, any time incl. mid-memory-access): state=T0, all strobes/read/write=0, control=ALU_NOP, run=1, illegal=0.
//  - Outputs are registered decodes of state: strobes valid for exactly the cycle the FSM sits in that step.
//  - At most one *out strobe active per cycle; Rin/Rout one-hot or zero.
//  - Fetch: T0 PCout,MARin,IncPc,Zin | T1 Zlowout,PCin,read,MDRin (stay until mem_ready) | T2 MDRout,IRin.
//  - Reg ALU (add,sub,and,or,shl,shr,rol,ror): T3 Rout[Rb],Yin | T4 Rout[Rc],control=op,Zin | T5 Zlowout,Rin[Ra] -> T0.
//  - Imm (addi,andi,ori): as above with Cout replacing Rout[Rc] in T4.
//  - neg/not: T4 Rout[Rb],control=op,Zin | T5 Zlowout,Rin[Ra]; T3 skipped.
//  - mul/div: T3 Rout[Ra],Yin | T4 Rout[Rb],control,Zin held MULDIV_CYCLES cycles (counter) | T5 Zlowout,LOin | T6 Zhighout,HIin.
//  - mfhi/mflo: T3 HIout|LOout, Rin[Ra] -> T0.
//  - ld: T3 Rout[Rb],Yin | T4 Cout,ADD,Zin | T5 Zlowout,MARin | T6 read,MDRin until mem_ready | T7 MDRout,Rin[Ra].
//  - st: T3-T5 as ld | T6 Rout[Ra],MDRin (read=0 selects bus) | T7 write until mem_ready.
//  - nop: T3 -> T0. halt: enter HALT, run=0, all strobes 0; leave only via reset.
//  - stop sampled at T0 entry: if 1, go HALT before any fetch strobe; stop mid-instruction completes the instruction first.
//  - mem_ready outside T1/T6(ld)/T7(st) is ignored; read and write are never both 1.
//  - Ra/Rb/Rc = 0 addresses R0 like any register (no zero special-case).
// CONFIGURATION
//  - ILLEGAL_TRAP_EN defined: undefined opcode at T3 -> HALT, illegal=1 (sticky until reset).
//  - Not defined: undefined opcode executes as nop; illegal tied 0.
// STRUCTURE
//  - Package ctrl_pkg: opcode constants (5b), ALU control codes (4b, incl. ALU_NOP/ADD), T-step/state encodings, IR field bit ranges.
//  - Sub-module reg_select_decoder: 4-bit field + enable -> 16-bit one-hot; three instances (Ra, Rb, Rc) muxed into Rin/Rout.
// TESTING
//  - Reset mid-T1 with read=1 -> read=0, tstate=0, run=1 next edge; fetch restarts from T0.
//  - add R3,R1,R2 (mem_ready immediate) -> T3 Rout=0x0002,Yin; T4 Rout=0x0004,control=ADD; T5 Rin=0x0008; 6 cycles total.
//  - ld R1,0x55(R2), mem_ready delayed 3 cycles in T6 -> read,MDRin held 4 cycles, then MDRout,Rin=0x0002.
//  - mul R4,R5 with MULDIV_CYCLES=4 -> Zin high exactly 4 cycles in T4, then LOin, then HIin, back to T0.
//  - st R6,0x10(R0) -> T6 Rout=0x0040,MDRin,read=0; write held until mem_ready; no Rin asserted anywhere.
//  - Opcode 0x1F: with ILLEGAL_TRAP_EN run=0,illegal=1; without, next T0 fetch; stop=1 at T0 -> run=0, no PCout.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the bus control sequencer: opcodes, ALU codes, FSM states,
// instruction classes, IR field positions and the strobe bundle.
package ctrl_pkg;

    localparam int SEL_W = 4;

    localparam logic [4:0] OP_LD   = 5'h00;
    localparam logic [4:0] OP_ST   = 5'h01;
    localparam logic [4:0] OP_ADD  = 5'h02;
    localparam logic [4:0] OP_SUB  = 5'h03;
    localparam logic [4:0] OP_AND  = 5'h04;
    localparam logic [4:0] OP_OR   = 5'h05;
    localparam logic [4:0] OP_SHL  = 5'h06;
    localparam logic [4:0] OP_SHR  = 5'h07;
    localparam logic [4:0] OP_ROL  = 5'h08;
    localparam logic [4:0] OP_ROR  = 5'h09;
    localparam logic [4:0] OP_ADDI = 5'h0A;
    localparam logic [4:0] OP_ANDI = 5'h0B;
    localparam logic [4:0] OP_ORI  = 5'h0C;
    localparam logic [4:0] OP_MUL  = 5'h0D;
    localparam logic [4:0] OP_DIV  = 5'h0E;
    localparam logic [4:0] OP_NEG  = 5'h0F;
    localparam logic [4:0] OP_NOT  = 5'h10;
    localparam logic [4:0] OP_MFHI = 5'h11;
    localparam logic [4:0] OP_MFLO = 5'h12;
    localparam logic [4:0] OP_NOP  = 5'h13;
    localparam logic [4:0] OP_HALT = 5'h14;

    localparam logic [3:0] ALU_NOP = 4'h0;
    localparam logic [3:0] ALU_ADD = 4'h1;
    localparam logic [3:0] ALU_SUB = 4'h2;
    localparam logic [3:0] ALU_AND = 4'h3;
    localparam logic [3:0] ALU_OR  = 4'h4;
    localparam logic [3:0] ALU_SHL = 4'h5;
    localparam logic [3:0] ALU_SHR = 4'h6;
    localparam logic [3:0] ALU_ROL = 4'h7;
    localparam logic [3:0] ALU_ROR = 4'h8;
    localparam logic [3:0] ALU_MUL = 4'h9;
    localparam logic [3:0] ALU_DIV = 4'hA;
    localparam logic [3:0] ALU_NEG = 4'hB;
    localparam logic [3:0] ALU_NOT = 4'hC;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    // S_BOOT is the post-reset T0 slot where stop is sampled before any fetch strobe.
    typedef enum logic [3:0] {
        S_T0   = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
        S_T4   = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
        S_BOOT = 4'd8, S_HALT = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU  = 4'd0, CL_IMM  = 4'd1, CL_UNARY = 4'd2, CL_MULDIV = 4'd3,
        CL_MFHI = 4'd4, CL_MFLO = 4'd5, CL_LD    = 4'd6, CL_ST     = 4'd7,
        CL_NOP  = 4'd8, CL_HALT = 4'd9, CL_ILL   = 4'd10
    } cls_t;

    typedef struct packed {
        logic       pc_out;
        logic       pc_in;
        logic       inc_pc;
        logic       ir_in;
        logic       mar_in;
        logic       mdr_in;
        logic       mdr_out;
        logic       y_in;
        logic       z_in;
        logic       zlow_out;
        logic       zhigh_out;
        logic       hi_in;
        logic       hi_out;
        logic       lo_in;
        logic       lo_out;
        logic       c_out;
        logic       read;
        logic       write;
        logic [3:0] control;
    } ctrl_t;

    function automatic cls_t op_class(input logic [4:0] op);
        cls_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: cls = CL_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:       cls = CL_IMM;
            OP_NEG, OP_NOT:                 cls = CL_UNARY;
            OP_MUL, OP_DIV:                 cls = CL_MULDIV;
            OP_MFHI:                        cls = CL_MFHI;
            OP_MFLO:                        cls = CL_MFLO;
            OP_LD:                          cls = CL_LD;
            OP_ST:                          cls = CL_ST;
            OP_NOP:                         cls = CL_NOP;
            OP_HALT:                        cls = CL_HALT;
            default:                        cls = CL_ILL;
        endcase
        return cls;
    endfunction

    function automatic logic [3:0] alu_code(input logic [4:0] op);
        logic [3:0] code;
        case (op)
            OP_ADD, OP_ADDI, OP_LD, OP_ST: code = ALU_ADD;
            OP_SUB:                        code = ALU_SUB;
            OP_AND, OP_ANDI:               code = ALU_AND;
            OP_OR, OP_ORI:                 code = ALU_OR;
            OP_SHL:                        code = ALU_SHL;
            OP_SHR:                        code = ALU_SHR;
            OP_ROL:                        code = ALU_ROL;
            OP_ROR:                        code = ALU_ROR;
            OP_MUL:                        code = ALU_MUL;
            OP_DIV:                        code = ALU_DIV;
            OP_NEG:                        code = ALU_NEG;
            OP_NOT:                        code = ALU_NOT;
            default:                       code = ALU_NOP;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Turns a 4-bit register field plus enable into a one-hot register select (all zero when idle).
module reg_select_decoder
    import ctrl_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);

    // One-hot decode; out-of-range selects yield no strobe rather than aliasing.
    always_comb begin
        onehot = {NREGS{1'b0}};
        if (en && (int'(sel) < NREGS)) begin
            onehot[sel] = 1'b1;
        end else begin
            onehot = {NREGS{1'b0}};
        end
    end

endmodule

// File: rtl/bus_control_sequencer.sv
// Hardwired fetch (T0-T2) / execute (T3-T7) sequencer for the single-bus datapath.
// Build option ILLEGAL_TRAP_EN: undefined opcodes halt and set a sticky illegal flag.
module bus_control_sequencer
    import ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4,
    parameter int NREGS         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    input  logic             stop,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic             PCout,
    output logic             PCin,
    output logic             IncPc,
    output logic             IRin,
    output logic             MARin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             Yin,
    output logic             Zin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             HIin,
    output logic             HIout,
    output logic             LOin,
    output logic             LOout,
    output logic             Cout,
    output logic [3:0]       control,
    output logic             read,
    output logic             write,
    output logic             run,
    output logic             illegal,
    output logic [2:0]       tstate
);

    localparam int CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MULDIV_CYCLES - 1);

    state_t           state_q, state_d, entry_s;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [4:0]       op_s;
    cls_t             cls_s;
    ctrl_t            ctrl_s, ctrl_d, ctrl_q;
    logic [NREGS-1:0] rin_d, rin_q, rout_d, rout_q;
    logic [NREGS-1:0] ra_oh_s, rb_oh_s, rc_oh_s;
    logic             ra_in_en_s, ra_out_en_s, rb_out_en_s, rc_out_en_s;
    logic             run_d, run_q;
    logic [2:0]       tstate_d, tstate_q;
    logic             unused_ir_s;
`ifdef ILLEGAL_TRAP_EN
    logic             illegal_d, illegal_q;
`endif

    assign op_s        = ir[OP_MSB:OP_LSB];
    assign cls_s       = op_class(op_s);
    assign entry_s     = stop ? S_HALT : S_T0;
    assign unused_ir_s = ^ir[RC_LSB-1:0];

    // Next-state, mul/div hold counter and sticky illegal flag.
    always_comb begin
        state_d = state_q;
`ifdef ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            S_BOOT: state_d = entry_s;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = mem_ready ? S_T2 : S_T1;
            S_T2:   state_d = (cls_s == CL_UNARY) ? S_T4 : S_T3;
            S_T3: begin
                case (cls_s)
                    CL_NOP, CL_MFHI, CL_MFLO: state_d = entry_s;
                    CL_HALT:                  state_d = S_HALT;
                    CL_ILL: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
`else
                        state_d = entry_s;
`endif
                    end
                    default: state_d = S_T4;
                endcase
            end
            S_T4: state_d = (cls_s == CL_MULDIV && cnt_q != {CW{1'b0}}) ? S_T4 : S_T5;
            S_T5: begin
                case (cls_s)
                    CL_MULDIV, CL_LD, CL_ST: state_d = S_T6;
                    default:                 state_d = entry_s;
                endcase
            end
            S_T6: begin
                case (cls_s)
                    CL_LD:   state_d = mem_ready ? S_T7 : S_T6;
                    CL_ST:   state_d = S_T7;
                    default: state_d = entry_s;
                endcase
            end
            S_T7: begin
                case (cls_s)
                    CL_ST:   state_d = mem_ready ? entry_s : S_T7;
                    default: state_d = entry_s;
                endcase
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase

        if (state_q == S_T4) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = CNT_INIT;
        end
    end

    // Strobe decode of the step being entered, so the registered outputs line up with state_q.
    always_comb begin
        ctrl_s         = '0;
        ctrl_s.control = ALU_NOP;
        ra_in_en_s     = 1'b0;
        ra_out_en_s    = 1'b0;
        rb_out_en_s    = 1'b0;
        rc_out_en_s    = 1'b0;
        case (state_d)
            S_T0: begin
                ctrl_s.pc_out = 1'b1;
                ctrl_s.mar_in = 1'b1;
                ctrl_s.inc_pc = 1'b1;
                ctrl_s.z_in   = 1'b1;
            end
            S_T1: begin
                ctrl_s.zlow_out = 1'b1;
                ctrl_s.pc_in    = 1'b1;
                ctrl_s.read     = 1'b1;
                ctrl_s.mdr_in   = 1'b1;
            end
            S_T2: begin
                ctrl_s.mdr_out = 1'b1;
                ctrl_s.ir_in   = 1'b1;
            end
            S_T3: begin
                case (cls_s)
                    CL_ALU, CL_IMM, CL_LD, CL_ST: begin
                        rb_out_en_s = 1'b1;
                        ctrl_s.y_in = 1'b1;
                    end
                    CL_MULDIV: begin
                        ra_out_en_s = 1'b1;
                        ctrl_s.y_in = 1'b1;
                    end
                    CL_MFHI: begin
                        ctrl_s.hi_out = 1'b1;
                        ra_in_en_s    = 1'b1;
                    end
                    CL_MFLO: begin
                        ctrl_s.lo_out = 1'b1;
                        ra_in_en_s    = 1'b1;
                    end
                    default: ctrl_s.y_in = 1'b0;
                endcase
            end
            S_T4: begin
                ctrl_s.z_in    = 1'b1;
                ctrl_s.control = alu_code(op_s);
                case (cls_s)
                    CL_ALU:               rc_out_en_s  = 1'b1;
                    CL_IMM, CL_LD, CL_ST: ctrl_s.c_out = 1'b1;
                    CL_UNARY, CL_MULDIV:  rb_out_en_s  = 1'b1;
                    default:              ctrl_s.z_in  = 1'b0;
                endcase
            end
            S_T5: begin
                ctrl_s.zlow_out = 1'b1;
                case (cls_s)
                    CL_MULDIV:    ctrl_s.lo_in  = 1'b1;
                    CL_LD, CL_ST: ctrl_s.mar_in = 1'b1;
                    default:      ra_in_en_s    = 1'b1;
                endcase
            end
            S_T6: begin
                case (cls_s)
                    CL_MULDIV: begin
                        ctrl_s.zhigh_out = 1'b1;
                        ctrl_s.hi_in     = 1'b1;
                    end
                    CL_LD: begin
                        ctrl_s.read   = 1'b1;
                        ctrl_s.mdr_in = 1'b1;
                    end
                    CL_ST: begin
                        ra_out_en_s   = 1'b1;
                        ctrl_s.mdr_in = 1'b1;
                    end
                    default: ctrl_s.mdr_in = 1'b0;
                endcase
            end
            S_T7: begin
                case (cls_s)
                    CL_LD: begin
                        ctrl_s.mdr_out = 1'b1;
                        ra_in_en_s     = 1'b1;
                    end
                    CL_ST:   ctrl_s.write = 1'b1;
                    default: ctrl_s.write = 1'b0;
                endcase
            end
            default: ctrl_s.z_in = 1'b0;
        endcase
    end

    reg_select_decoder #(.NREGS(NREGS)) u_ra_dec (
        .sel    (ir[RA_MSB:RA_LSB]),
        .en     (ra_in_en_s | ra_out_en_s),
        .onehot (ra_oh_s)
    );

    reg_select_decoder #(.NREGS(NREGS)) u_rb_dec (
        .sel    (ir[RB_MSB:RB_LSB]),
        .en     (rb_out_en_s),
        .onehot (rb_oh_s)
    );

    reg_select_decoder #(.NREGS(NREGS)) u_rc_dec (
        .sel    (ir[RC_MSB:RC_LSB]),
        .en     (rc_out_en_s),
        .onehot (rc_oh_s)
    );

    // Merge the register selects and derive run/tstate for the step being entered.
    always_comb begin
        ctrl_d = ctrl_s;
        rin_d  = ra_in_en_s  ? ra_oh_s : {NREGS{1'b0}};
        rout_d = ra_out_en_s ? ra_oh_s : (rb_oh_s | rc_oh_s);
        run_d  = (state_d != S_HALT);
        if (state_d == S_HALT || state_d == S_BOOT) begin
            tstate_d = 3'd0;
        end else begin
            tstate_d = state_d[2:0];
        end
    end

    // Sequencer state and registered control outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_BOOT;
            cnt_q          <= CNT_INIT;
            ctrl_q         <= '0;
            ctrl_q.control <= ALU_NOP;
            rin_q          <= {NREGS{1'b0}};
            rout_q         <= {NREGS{1'b0}};
            run_q          <= 1'b1;
            tstate_q       <= 3'd0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ctrl_q         <= ctrl_d;
            rin_q          <= rin_d;
            rout_q         <= rout_d;
            run_q          <= run_d;
            tstate_q       <= tstate_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q      <= illegal_d;
`endif
        end
    end

    assign Rin      = rin_q;
    assign Rout     = rout_q;
    assign PCout    = ctrl_q.pc_out;
    assign PCin     = ctrl_q.pc_in;
    assign IncPc    = ctrl_q.inc_pc;
    assign IRin     = ctrl_q.ir_in;
    assign MARin    = ctrl_q.mar_in;
    assign MDRin    = ctrl_q.mdr_in;
    assign MDRout   = ctrl_q.mdr_out;
    assign Yin      = ctrl_q.y_in;
    assign Zin      = ctrl_q.z_in;
    assign Zlowout  = ctrl_q.zlow_out;
    assign Zhighout = ctrl_q.zhigh_out;
    assign HIin     = ctrl_q.hi_in;
    assign HIout    = ctrl_q.hi_out;
    assign LOin     = ctrl_q.lo_in;
    assign LOout    = ctrl_q.lo_out;
    assign Cout     = ctrl_q.c_out;
    assign control  = ctrl_q.control;
    assign read     = ctrl_q.read;
    assign write    = ctrl_q.write;
    assign run      = run_q;
    assign tstate   = tstate_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal  = illegal_q;
`else
    assign illegal  = 1'b0;
`endif

endmodule
